// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
// Time-setting controller for the digital clock. Sits between the two
// front-panel buttons (MODE, INC) and the sec/min/hour/day counter chain.
// MODE steps RUN -> SEC -> MIN -> HOUR -> DAY -> RUN. INC (pressed or held)
// pulses the counter selected by the current edit state. An edit state with
// no activity for TIMEOUT_S seconds falls back to RUN.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   tick_1hz  one-cycle 1 Hz enable, synchronous to clk
//   btn_mode  raw MODE button (active-high, asynchronous)
//   btn_inc   raw INC button (active-high, asynchronous)
//   run_en    1 = counters advance on tick_1hz, 0 = counting frozen
//   inc_sec   one-cycle increment pulse to the seconds counter
//   inc_min   one-cycle increment pulse to the minutes counter
//   inc_hour  one-cycle increment pulse to the hours counter
//   inc_day   one-cycle increment pulse to the days counter
//   edit_sel  0 = RUN, 1 = SEC, 2 = MIN, 3 = HOUR, 4 = DAY
//   blink     display blank flag for the field being edited
module clock_set_ctrl #(
  parameter int DEB_CYCLES    = 4,
  parameter int REPEAT_CYCLES = 16,
  parameter int TIMEOUT_S     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       run_en,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hour,
  output logic       inc_day,
  output logic [2:0] edit_sel,
  output logic       blink
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int RW = $clog2(REPEAT_CYCLES);

  typedef enum logic [2:0] {
    ST_RUN  = 3'd0,
    ST_SEC  = 3'd1,
    ST_MIN  = 3'd2,
    ST_HOUR = 3'd3,
    ST_DAY  = 3'd4
  } state_t;

  // Button bit 0 is MODE, bit 1 is INC.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_d;
  logic [1:0]    press;
  logic [DW-1:0] deb_cnt [2];

  state_t        state;
  state_t        next_state;
  logic          entry;
  logic [RW-1:0] rcnt;
  logic [7:0]    idle_cnt;
  logic          rep_fire;
  logic          inc_fire;

  logic          press_mode;
  logic          press_inc;
  logic          deb_inc;

  assign press_mode = press[0];
  assign press_inc  = press[1];
  assign deb_inc    = deb[1];

  // Synchronize, debounce and edge-detect both buttons. A level change is
  // accepted only after DEB_CYCLES consecutive differing samples; press is a
  // registered pulse on the rising edge of the debounced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      deb        <= '0;
      deb_d      <= '0;
      press      <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync1 <= {btn_inc, btn_mode};
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Next state and increment request. A mode press beats a simultaneous inc
  // press, and any inc press or repeat beats the idle timeout.
  always_comb begin
    next_state = state;
    rep_fire   = 1'b0;
    inc_fire   = 1'b0;
    if (state != ST_RUN) begin
      rep_fire = deb_inc && !press_inc && !press_mode &&
                 (rcnt == RW'(REPEAT_CYCLES - 1));
      inc_fire = (press_inc && !press_mode) || rep_fire;
    end
    if (press_mode) begin
      case (state)
        ST_RUN:  next_state = ST_SEC;
        ST_SEC:  next_state = ST_MIN;
        ST_MIN:  next_state = ST_HOUR;
        ST_HOUR: next_state = ST_DAY;
        default: next_state = ST_RUN;
      endcase
    end else if ((state != ST_RUN) && !inc_fire && tick_1hz &&
                 (idle_cnt == 8'(TIMEOUT_S - 1))) begin
      next_state = ST_RUN;
    end
  end

  // State register plus the repeat and idle counters that depend on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      entry    <= 1'b0;
      rcnt     <= '0;
      idle_cnt <= '0;
    end else begin
      state <= next_state;
      entry <= (next_state != state);

      if ((state == ST_RUN) || (next_state == ST_RUN) || !deb_inc ||
          press_inc || rep_fire) begin
        rcnt <= '0;
      end else begin
        rcnt <= rcnt + RW'(1);
      end

      if ((state == ST_RUN) || (next_state != state) || press_inc ||
          press_mode || rep_fire) begin
        idle_cnt <= '0;
      end else if (tick_1hz) begin
        idle_cnt <= idle_cnt + 8'd1;
      end
    end
  end

  // Registered outputs follow the current state, so they settle one cycle
  // after a state change. entry marks the first cycle in a new state and is
  // used to restart the blink phase for the newly selected field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_en   <= 1'b1;
      edit_sel <= 3'd0;
      blink    <= 1'b0;
      inc_sec  <= 1'b0;
      inc_min  <= 1'b0;
      inc_hour <= 1'b0;
      inc_day  <= 1'b0;
    end else begin
      run_en   <= (state == ST_RUN);
      edit_sel <= state;
      inc_sec  <= inc_fire && (state == ST_SEC);
      inc_min  <= inc_fire && (state == ST_MIN);
      inc_hour <= inc_fire && (state == ST_HOUR);
      inc_day  <= inc_fire && (state == ST_DAY);
      if ((state == ST_RUN) || entry) begin
        blink <= 1'b0;
      end else if (tick_1hz) begin
        blink <= ~blink;
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl
// Directed self-checking bench for clock_set_ctrl with default parameters
// (DEB_CYCLES=4, REPEAT_CYCLES=16, TIMEOUT_S=3). Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_clock_set_ctrl;

  logic       clk;
  logic       rst;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic       run_en;
  logic       inc_sec;
  logic       inc_min;
  logic       inc_hour;
  logic       inc_day;
  logic [2:0] edit_sel;
  logic       blink;
  logic [3:0] incs;

  int checks;
  int failures;

  assign incs = {inc_day, inc_hour, inc_min, inc_sec};

  clock_set_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .run_en   (run_en),
    .inc_sec  (inc_sec),
    .inc_min  (inc_min),
    .inc_hour (inc_hour),
    .inc_day  (inc_day),
    .edit_sel (edit_sel),
    .blink    (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick_1hz = 1'b0;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(2);
  endtask

  task automatic press_mode_btn(input int high, input int low);
    btn_mode = 1'b1;
    wait_cycles(high);
    btn_mode = 1'b0;
    wait_cycles(low);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (run_en !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_run_en: got %b expected 1", run_en);
    end
    checks++;
    if (edit_sel !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_edit_sel: got %0d expected 0", edit_sel);
    end
    checks++;
    if (blink !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_blink: got %b expected 0", blink);
    end
    checks++;
    if (incs !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_incs: got %b expected 0000", incs);
    end
  endtask

  task automatic test_run_ignores_inc();
    int pulses;
    int run_low;
    int sel_bad;
    pulses  = 0;
    run_low = 0;
    sel_bad = 0;
    do_reset();
    btn_inc = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 50) btn_inc = 1'b0;
      if (incs != 4'b0000) pulses++;
      if (run_en !== 1'b1) run_low++;
      if (edit_sel !== 3'd0) sel_bad++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("[TB] FAIL run_inc_pulses: got %0d expected 0", pulses);
    end
    checks++;
    if (run_low != 0) begin
      failures++;
      $display("[TB] FAIL run_en_held: got %0d low cycles expected 0", run_low);
    end
    checks++;
    if (sel_bad != 0) begin
      failures++;
      $display("[TB] FAIL run_edit_sel: got %0d bad cycles expected 0", sel_bad);
    end
  endtask

  task automatic test_inc_latency();
    int first_k;
    int sec_pulses;
    int other_pulses;
    first_k      = -1;
    sec_pulses   = 0;
    other_pulses = 0;
    do_reset();
    press_mode_btn(20, 15);
    checks++;
    if (edit_sel !== 3'd1) begin
      failures++;
      $display("[TB] FAIL sec_edit_sel: got %0d expected 1", edit_sel);
    end
    checks++;
    if (run_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sec_run_en: got %b expected 0", run_en);
    end
    btn_inc = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 8) btn_inc = 1'b0;
      if (inc_sec === 1'b1) begin
        sec_pulses++;
        if (first_k < 0) first_k = k;
      end
      if ({inc_day, inc_hour, inc_min} != 3'b000) other_pulses++;
    end
    checks++;
    if (first_k != 8) begin
      failures++;
      $display("[TB] FAIL inc_latency: got %0d expected 8", first_k);
    end
    checks++;
    if (sec_pulses != 1) begin
      failures++;
      $display("[TB] FAIL inc_sec_count: got %0d expected 1", sec_pulses);
    end
    checks++;
    if (other_pulses != 0) begin
      failures++;
      $display("[TB] FAIL inc_other_count: got %0d expected 0", other_pulses);
    end
  endtask

  task automatic test_mode_cycle();
    logic [2:0] exp_sel;
    do_reset();
    btn_mode = 1'b1;
    wait_cycles(3);
    btn_mode = 1'b0;
    wait_cycles(15);
    checks++;
    if (edit_sel !== 3'd0) begin
      failures++;
      $display("[TB] FAIL glitch_edit_sel: got %0d expected 0", edit_sel);
    end
    exp_sel = 3'd0;
    for (int p = 1; p <= 5; p++) begin
      press_mode_btn(10, 10);
      exp_sel = (p == 5) ? 3'd0 : 3'(p);
      checks++;
      if (edit_sel !== exp_sel) begin
        failures++;
        $display("[TB] FAIL mode_step%0d: got %0d expected %0d", p, edit_sel, exp_sel);
      end
    end
    checks++;
    if (run_en !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mode_wrap_run_en: got %b expected 1", run_en);
    end
  endtask

  task automatic test_auto_repeat();
    int hour_pulses;
    int other_pulses;
    int bad;
    hour_pulses  = 0;
    other_pulses = 0;
    bad          = 0;
    do_reset();
    for (int p = 0; p < 3; p++) press_mode_btn(10, 10);
    checks++;
    if (edit_sel !== 3'd3) begin
      failures++;
      $display("[TB] FAIL hour_edit_sel: got %0d expected 3", edit_sel);
    end
    btn_inc = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (k == 60) btn_inc = 1'b0;
      if (inc_hour === 1'b1) hour_pulses++;
      if ({inc_day, inc_min, inc_sec} != 3'b000) other_pulses++;
      if (incs != 4'b0000 && run_en === 1'b1) bad++;
    end
    checks++;
    if (hour_pulses != 4) begin
      failures++;
      $display("[TB] FAIL repeat_hour_count: got %0d expected 4", hour_pulses);
    end
    checks++;
    if (other_pulses != 0) begin
      failures++;
      $display("[TB] FAIL repeat_other_count: got %0d expected 0", other_pulses);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL repeat_inc_while_run: got %0d expected 0", bad);
    end
  endtask

  task automatic test_blink_timeout();
    logic [2:0] exp_blink;
    exp_blink = 3'b101;
    do_reset();
    for (int p = 0; p < 2; p++) press_mode_btn(10, 10);
    checks++;
    if (edit_sel !== 3'd2) begin
      failures++;
      $display("[TB] FAIL min_edit_sel: got %0d expected 2", edit_sel);
    end
    checks++;
    if (blink !== 1'b0) begin
      failures++;
      $display("[TB] FAIL min_blink_entry: got %b expected 0", blink);
    end
    for (int t = 0; t < 3; t++) begin
      tick_1hz = 1'b1;
      @(negedge clk);
      tick_1hz = 1'b0;
      checks++;
      if (blink !== exp_blink[t]) begin
        failures++;
        $display("[TB] FAIL blink_tick%0d: got %b expected %b", t + 1, blink, exp_blink[t]);
      end
      wait_cycles(4);
    end
    checks++;
    if (edit_sel !== 3'd0) begin
      failures++;
      $display("[TB] FAIL timeout_edit_sel: got %0d expected 0", edit_sel);
    end
    checks++;
    if (run_en !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_run_en: got %b expected 1", run_en);
    end
    checks++;
    if (blink !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_blink: got %b expected 0", blink);
    end
  endtask

  task automatic test_simultaneous();
    int pulses;
    pulses = 0;
    do_reset();
    press_mode_btn(10, 10);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 10) begin
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
      end
      if (incs != 4'b0000) pulses++;
    end
    checks++;
    if (edit_sel !== 3'd2) begin
      failures++;
      $display("[TB] FAIL simul_edit_sel: got %0d expected 2", edit_sel);
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("[TB] FAIL simul_inc_pulses: got %0d expected 0", pulses);
    end
  endtask

  task automatic test_reset_midop();
    int pulses;
    pulses = 0;
    do_reset();
    for (int p = 0; p < 4; p++) press_mode_btn(10, 10);
    checks++;
    if (edit_sel !== 3'd4) begin
      failures++;
      $display("[TB] FAIL day_edit_sel: got %0d expected 4", edit_sel);
    end
    btn_inc = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (inc_day === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("[TB] FAIL day_inc_count: got %0d expected 1", pulses);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (run_en !== 1'b1 || edit_sel !== 3'd0 || blink !== 1'b0 || incs !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL midop_reset: got run_en=%b edit_sel=%0d blink=%b incs=%b expected 1 0 0 0000",
               run_en, edit_sel, blink, incs);
    end
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (incs != 4'b0000) pulses++;
    end
    btn_inc = 1'b0;
    checks++;
    if (edit_sel !== 3'd0 || pulses != 0) begin
      failures++;
      $display("[TB] FAIL post_reset_held: got edit_sel=%0d pulses=%0d expected 0 0", edit_sel, pulses);
    end
    wait_cycles(10);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick_1hz = 1'b0;
    test_reset();
    test_run_ignores_inc();
    test_inc_latency();
    test_mode_cycle();
    test_auto_repeat();
    test_blink_timeout();
    test_simultaneous();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
